spi_master_fifo: RTL and testbench

// - Parametrised SPI master for CPU/MCU-side use. Next generation of the 8-bit SPI interface:

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_fifo.sv | 50 +++++
 rtl/spi_master_fifo.sv | 180 ++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding, SPI mode constants and helpers for the SPI master
package spi_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} spi_state_e;

  localparam logic CPOL_LOW   = 1'b0;
  localparam logic CPOL_HIGH  = 1'b1;
  localparam logic CPHA_LEAD  = 1'b0;
  localparam logic CPHA_TRAIL = 1'b1;

  function automatic int spi_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and show-ahead head word
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = spi_clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
    rd_d    = do_pop ? rd_q + PTR_ONE : rd_q;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = push_data;
  end

  assign head = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/spi_master_fifo.sv
// rtl/spi_master_fifo.sv - SPI master with TX/RX FIFOs, runtime CPOL/CPHA, S_CLK divider, chip selects
module spi_master_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS     = 2,
  parameter int DIV_W      = 8
) (
  input  logic                           CLK,
  input  logic                           CLR,
  input  logic                           CPOL,
  input  logic                           CPHA,
  input  logic [DIV_W-1:0]               CLK_DIV,
  input  logic [spi_clog2(NUM_CS+1)-1:0] CS_SEL,
  input  logic [DATA_W-1:0]              TX_DATA,
  input  logic                           TX_VALID,
  output logic                           TX_READY,
  output logic [DATA_W-1:0]              RX_DATA,
  output logic                           RX_VALID,
  input  logic                           RX_READY,
  output logic                           BUSY,
  output logic                           OVERRUN,
  input  logic                           OVR_CLR,
  output logic                           S_CLK,
  output logic                           MOSI,
  input  logic                           MISO,
  output logic [NUM_CS-1:0]              CS_N
);
  localparam int CS_W   = spi_clog2(NUM_CS + 1);
  localparam int EDGE_W = spi_clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

  spi_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d, div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic              s_clk_q, s_clk_d, mosi_q, mosi_d, ovr_q, ovr_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              half_end, fire, lead, tx_pop, rx_push;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_head;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < NUM_CS; i++) if (int'(sel) == i) cs_decode[i] = 1'b0;
  endfunction

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(CLK), .rst_n(CLR), .push(TX_VALID && !tx_full), .push_data(TX_DATA),
    .pop(tx_pop), .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(CLK), .rst_n(CLR), .push(rx_push), .push_data(rx_sh_q),
    .pop(RX_READY), .full(rx_full), .empty(rx_empty), .head(RX_DATA)
  );

  // received word goes in during the first HOLD cycle, so RX_VALID follows HOLD entry by one cycle
  assign rx_push = (state_q == ST_HOLD) && (div_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q + DIV_ONE;
    div_d     = div_q;
    edge_d    = edge_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    s_clk_d   = s_clk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    tx_pop    = 1'b0;
    fire      = 1'b0;
    lead      = 1'b0;
    half_end  = (div_cnt_q == div_q);
    ovr_d     = (rx_push && rx_full) ? 1'b1 : (OVR_CLR ? 1'b0 : ovr_q);

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        s_clk_d   = CPOL;
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          cpol_d  = CPOL;
          cpha_d  = CPHA;
          div_d   = CLK_DIV;
          cs_n_d  = cs_decode(CS_SEL);
          state_d = ST_SETUP;
          if (CPHA == CPHA_LEAD) begin
            mosi_d  = tx_head[DATA_W-1];
            tx_sh_d = tx_head << 1;
          end else begin
            tx_sh_d = tx_head;
          end
        end
      end
      ST_SETUP: if (half_end) begin
        state_d   = ST_SHIFT;
        div_cnt_d = '0;
        edge_d    = '0;
        fire      = 1'b1;
        lead      = 1'b1;
      end
      ST_SHIFT: if (half_end) begin
        div_cnt_d = '0;
        if (edge_q == LAST_EDGE) begin
          state_d = ST_HOLD;
        end else begin
          edge_d = edge_q + EDGE_ONE;
          fire   = 1'b1;
          lead   = edge_q[0];
        end
      end
      ST_HOLD: if (half_end) begin
        state_d   = ST_GAP;
        div_cnt_d = '0;
        cs_n_d    = '1;
      end
      ST_GAP: if (half_end) begin
        state_d   = ST_IDLE;
        div_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // each S_CLK edge either samples MISO or advances MOSI, depending on which phase samples
    if (fire) begin
      s_clk_d = ~s_clk_q;
      if (lead ^ (cpha_q == CPHA_TRAIL)) begin
        rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
      end else begin
        mosi_d  = tx_sh_q[DATA_W-1];
        tx_sh_d = tx_sh_q << 1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      div_q     <= '0;
      edge_q    <= '0;
      cpol_q    <= CPOL_LOW;
      cpha_q    <= CPHA_LEAD;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      s_clk_q   <= CPOL_LOW;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      s_clk_q   <= s_clk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      ovr_q     <= ovr_d;
    end
  end

  assign TX_READY = !tx_full;
  assign RX_VALID = !rx_empty;
  assign BUSY     = (state_q != ST_IDLE);
  assign OVERRUN  = ovr_q;
  assign S_CLK    = s_clk_q;
  assign MOSI     = mosi_q;
  assign CS_N     = cs_n_q;
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb/tb_spi_master_fifo.sv - directed scoreboard bench for spi_master_fifo
module tb_spi_master_fifo;
  import spi_pkg::*;

  logic       CLK = 1'b0;
  logic       CLR, CPOL, CPHA, TX_VALID, RX_READY, OVR_CLR;
  logic [7:0] CLK_DIV, TX_DATA;
  logic [1:0] CS_SEL;
  logic       TX_READY, RX_VALID, BUSY, OVERRUN, S_CLK, MOSI, MISO;
  logic [7:0] RX_DATA;
  logic [1:0] CS_N;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  logic       loop_en = 1'b1;
  logic [7:0] slv_word = 8'h00;
  logic [7:0] slv_sh = 8'h00;
  logic       slv_bit = 1'b0;
  logic       slv_cs_prev = 1'b1;

  int busy_total = 0, cs0_low_total = 0, cs_any_total = 0, cs1_frames = 0, cs_run = 0;
  int sclk_rise_total = 0;
  int gap_hist[64];
  logic [1:0] cs_prev = 2'bxx;
  logic [7:0] mosi_cap = 8'h00;

  spi_master_fifo dut (
    .CLK(CLK), .CLR(CLR), .CPOL(CPOL), .CPHA(CPHA), .CLK_DIV(CLK_DIV), .CS_SEL(CS_SEL),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .BUSY(BUSY), .OVERRUN(OVERRUN), .OVR_CLR(OVR_CLR),
    .S_CLK(S_CLK), .MOSI(MOSI), .MISO(MISO), .CS_N(CS_N)
  );

  always #5 CLK = ~CLK;

  assign MISO = loop_en ? MOSI : slv_bit;

  // CPHA=1 slave on CS_N[0]: next bit appears on each falling (leading, CPOL=1) S_CLK edge
  always @(CS_N[0] or negedge S_CLK) begin
    if (CS_N[0] !== slv_cs_prev) begin
      if (CS_N[0] === 1'b0) slv_sh = slv_word;
      slv_cs_prev = CS_N[0];
    end else if (CS_N[0] === 1'b0 && S_CLK === 1'b0) begin
      slv_bit = slv_sh[7];
      slv_sh  = {slv_sh[6:0], 1'b0};
    end
  end

  always @(posedge S_CLK) begin
    if (BUSY === 1'b1) begin
      sclk_rise_total++;
      mosi_cap = {mosi_cap[6:0], MOSI};
    end
  end

  always @(negedge CLK) begin
    if (BUSY === 1'b1) busy_total++;
    if (CS_N[0] === 1'b0) cs0_low_total++;
    if (CS_N !== 2'b11) cs_any_total++;
    if (CS_N === 2'b01) begin
      if (cs_prev === 2'b11) begin
        gap_hist[cs1_frames % 64] = cs_run;
        cs1_frames++;
      end
      cs_run = 0;
    end else if (CS_N === 2'b11) begin
      cs_run++;
    end else begin
      cs_run = 0;
    end
    cs_prev = CS_N;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    int i;
    for (i = 0; i < 2000 && TX_READY !== 1'b1; i++) @(negedge CLK);
    if (TX_READY !== 1'b1) chk("push_timeout", {31'd0, TX_READY}, 32'd1);
    TX_DATA  = d;
    TX_VALID = 1'b1;
    @(negedge CLK);
    TX_VALID = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int i;
    logic [7:0] exp;
    for (i = 0; i < 3000 && RX_VALID !== 1'b1; i++) @(negedge CLK);
    if (RX_VALID !== 1'b1) begin
      chk({tag, "_timeout"}, {31'd0, RX_VALID}, 32'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, {24'd0, RX_DATA}, 32'hFFFF_FFFF);
    end else begin
      exp = sb.pop_front();
      chk(tag, {24'd0, RX_DATA}, {24'd0, exp});
      RX_READY = 1'b1;
      @(negedge CLK);
      RX_READY = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int run;
    int i;
    run = 0;
    for (i = 0; i < 5000 && run < 4; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b0) run++;
      else run = 0;
    end
    if (run < 4) chk("idle_timeout", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0_0, rise_0, f0, busy_0, any_0;
    CLR = 1'b0; CPOL = CPOL_LOW; CPHA = CPHA_LEAD; CLK_DIV = 8'd0; CS_SEL = 2'd0;
    TX_DATA = 8'h00; TX_VALID = 1'b0; RX_READY = 1'b0; OVR_CLR = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_cs_n", {30'd0, CS_N}, 32'h3);
    chk("rst_sclk", {31'd0, S_CLK}, 32'd0);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_overrun", {31'd0, OVERRUN}, 32'd0);
    chk("rst_tx_ready", {31'd0, TX_READY}, 32'd1);
    chk("rst_rx_valid", {31'd0, RX_VALID}, 32'd0);
    CLR = 1'b1;
    repeat (2) @(negedge CLK);

    // mode 0, h=2, loopback
    CLK_DIV = 8'd1;
    cs0_0 = cs0_low_total; rise_0 = sclk_rise_total;
    push_word(8'hA5); sb.push_back(8'hA5);
    wait_idle();
    chk("m0_cs_low_cycles", cs0_low_total - cs0_0, 32'd36);
    chk("m0_sclk_rises", sclk_rise_total - rise_0, 32'd8);
    chk("m0_mosi_bits", {24'd0, mosi_cap}, 32'hA5);
    pop_check("m0_rx");

    // mode 3, h=1, slave returns 0x3C
    CPOL = CPOL_HIGH; CPHA = CPHA_TRAIL; CLK_DIV = 8'd0; loop_en = 1'b0; slv_word = 8'h3C;
    @(negedge CLK);
    chk("m3_sclk_idle_high", {31'd0, S_CLK}, 32'd1);
    cs0_0 = cs0_low_total; rise_0 = sclk_rise_total;
    push_word(8'hC3); sb.push_back(8'h3C);
    wait_idle();
    chk("m3_mosi_bits", {24'd0, mosi_cap}, 32'hC3);
    chk("m3_sclk_rises", sclk_rise_total - rise_0, 32'd8);
    chk("m3_cs_low_cycles", cs0_low_total - cs0_0, 32'd18);
    chk("m3_sclk_after", {31'd0, S_CLK}, 32'd1);
    pop_check("m3_rx");

    // overrun: RX_READY held low across FIFO_DEPTH+1 frames
    CPOL = CPOL_LOW; CPHA = CPHA_LEAD; loop_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push_word(8'(k));
      if (k <= 4) sb.push_back(8'(k));
    end
    wait_idle();
    chk("ovr_set", {31'd0, OVERRUN}, 32'd1);
    for (int k = 1; k <= 4; k++) pop_check("ovr_rx");
    chk("ovr_rx_drained", {31'd0, RX_VALID}, 32'd0);
    chk("ovr_held", {31'd0, OVERRUN}, 32'd1);
    OVR_CLR = 1'b1;
    @(negedge CLK);
    OVR_CLR = 1'b0;
    chk("ovr_cleared", {31'd0, OVERRUN}, 32'd0);

    // CS_SEL=1, h=2, back-to-back frames
    CS_SEL = 2'd1; CLK_DIV = 8'd1;
    f0 = cs1_frames; cs0_0 = cs0_low_total;
    for (int k = 0; k < 5; k++) begin
      push_word(8'h30 + 8'(k));
      sb.push_back(8'h30 + 8'(k));
    end
    chk("cs1_tx_full", {31'd0, TX_READY}, 32'd0);
    for (int k = 0; k < 5; k++) pop_check("cs1_rx");
    wait_idle();
    chk("cs1_frames", cs1_frames - f0, 32'd5);
    for (int k = 1; k <= 4; k++) chk("cs1_gap_len", gap_hist[(f0 + k) % 64], 32'd3);
    chk("cs1_cs0_untouched", cs0_low_total - cs0_0, 32'd0);
    chk("cs1_no_overrun", {31'd0, OVERRUN}, 32'd0);

    // asynchronous reset during SHIFT, second word queued behind it
    CS_SEL = 2'd0; CLK_DIV = 8'd3;
    push_word(8'hFF);
    push_word(8'hFF);
    for (int i = 0; i < 100 && BUSY !== 1'b1; i++) @(negedge CLK);
    repeat (12) @(negedge CLK);
    CLR = 1'b0;
    #1;
    chk("abort_cs_n", {30'd0, CS_N}, 32'h3);
    chk("abort_sclk", {31'd0, S_CLK}, 32'd0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_rx_valid", {31'd0, RX_VALID}, 32'd0);
    chk("abort_tx_ready", {31'd0, TX_READY}, 32'd1);
    @(negedge CLK);
    CLR = 1'b1;
    busy_0 = busy_total;
    repeat (60) @(negedge CLK);
    chk("abort_no_frame", busy_total - busy_0, 32'd0);
    chk("abort_rx_empty", {31'd0, RX_VALID}, 32'd0);

    // CS_SEL beyond NUM_CS: frame clocks with every chip select deasserted
    CS_SEL = 2'd2; CLK_DIV = 8'd0;
    busy_0 = busy_total; any_0 = cs_any_total;
    push_word(8'h5A); sb.push_back(8'h5A);
    wait_idle();
    chk("nosel_busy_cycles", busy_total - busy_0, 32'd19);
    chk("nosel_cs_high", cs_any_total - any_0, 32'd0);
    pop_check("nosel_rx");
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
